// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLANK = 2'd2
    } seg_arb_state_t;

    localparam int DISP_W = 16;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle for seg_display_arbiter; the arbiter side uses the master modport.
// The blink vector exists only when SEG_ARB_BLINK_EN is defined.
interface seg_display_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    import seg_arb_pkg::*;

    // Handshake: a source holds req high while it wants the display; it owns the
    // display exactly while its gnt bit is high, and gnt is one-hot or all zero.
    logic [N_REQ-1:0]        req;
    logic [DISP_W*N_REQ-1:0] data_in;
`ifdef SEG_ARB_BLINK_EN
    logic [N_REQ-1:0]        blink;
`endif
    logic [N_REQ-1:0]        gnt;
    logic [OW-1:0]           owner;
    logic                    owner_valid;
    logic [DISP_W-1:0]       disp_data;
    logic                    disp_enable;
    seg_arb_state_t          state;

    modport master (
        input  req, data_in,
`ifdef SEG_ARB_BLINK_EN
        input  blink,
`endif
        output gnt, owner, owner_valid, disp_data, disp_enable, state
    );

    modport slave (
        output req, data_in,
`ifdef SEG_ARB_BLINK_EN
        output blink,
`endif
        input  gnt, owner, owner_valid, disp_data, disp_enable, state
    );

endinterface

// File: rtl/seg_display_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted req at last+1, last+2, ... mod N_REQ.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [OW-1:0]    i_last,
    output logic             o_found,
    output logic [OW-1:0]    o_idx
);

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            int j;
            j = (int'(i_last) + k) % N_REQ;
            if (i_req[j]) begin
                o_found = 1'b1;
                o_idx   = OW'(j);
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with minimum hold and a one-cycle blank
// on every owner change. Optional blink of disp_enable under SEG_ARB_BLINK_EN.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_CYCLES  = 25000000
`ifdef SEG_ARB_BLINK_EN
    ,
    parameter int BLINK_CYCLES = 12500000
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg_display_arbiter_if.master  bus
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    seg_arb_state_t      r_state;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_last;
    logic [CW-1:0]       r_hold;
    logic [DISP_W-1:0]   r_data;

    logic                w_found;
    logic [OW-1:0]       w_pick;
    logic [N_REQ-1:0]    w_owner_mask;
    logic                w_owner_req;
    logic                w_others_req;
    logic                w_leave;
    logic [DISP_W-1:0]   w_owner_data;
    logic [DISP_W-1:0]   w_pick_data;

    rr_picker #(.N_REQ(N_REQ), .OW(OW)) u_picker (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_comb begin
        w_owner_mask          = '0;
        w_owner_mask[r_owner] = 1'b1;
    end

    assign w_owner_req  = |(bus.req & w_owner_mask);
    assign w_others_req = |(bus.req & ~w_owner_mask);
    // Release wins over preemption; both lead to BLANK with the same bookkeeping.
    assign w_leave      = !w_owner_req || ((r_hold == HOLD_MAX) && w_others_req);
    assign w_owner_data = bus.data_in[int'(r_owner)*DISP_W +: DISP_W];
    assign w_pick_data  = bus.data_in[int'(w_pick)*DISP_W +: DISP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= OW'(N_REQ - 1);
            r_hold  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE, BLANK: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_owner <= w_pick;
                        r_data  <= w_pick_data;
                        r_hold  <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    r_data <= w_owner_data;
                    if (w_leave) begin
                        r_state <= BLANK;
                        r_last  <= r_owner;
                        r_hold  <= '0;
                    end else if (r_hold != HOLD_MAX) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.gnt = '0;
        if (r_state == GRANT) bus.gnt = w_owner_mask;
    end

    assign bus.owner       = r_owner;
    assign bus.owner_valid = (r_state == GRANT);
    assign bus.disp_data   = r_data;
    assign bus.state       = r_state;

`ifdef SEG_ARB_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic          w_blink_sel;

    assign w_blink_sel = |(bus.blink & w_owner_mask);

    // Held at "on, count 0" outside GRANT so every grant starts with a lit display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_state != GRANT || !w_blink_sel) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign bus.disp_enable = (r_state == GRANT) && r_blink_on;
`else
    assign bus.disp_enable = (r_state == GRANT);
`endif

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed scoreboard bench for seg_display_arbiter (N_REQ=4, HOLD_CYCLES=8).
module tb_seg_display_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg_display_arbiter_if #(.N_REQ(4)) bus ();

    seg_display_arbiter #(.N_REQ(4), .HOLD_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Packed view: {gnt[3:0], owner_valid, disp_enable, owner[1:0], disp_data[15:0]}
    logic [23:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc_n    = 0;
    logic [15:0] d [4];

    function automatic logic [23:0] mk(input logic [3:0] g, input logic [1:0] o,
                                       input logic [15:0] dd);
        return {g, |g, |g, o, dd};
    endfunction

    function automatic logic [23:0] actual();
        return {bus.gnt, bus.owner_valid, bus.disp_enable, bus.owner, bus.disp_data};
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got gnt=%b ov=%b en=%b owner=%0d data=%h, expected gnt=%b ov=%b en=%b owner=%0d data=%h",
                     nm, act[23:20], act[19], act[18], act[17:16], act[15:0],
                     exp[23:20], exp[19], exp[18], exp[17:16], exp[15:0]);
        end
    endtask

    // Driver: apply req/data away from the edge and queue the post-edge expectation.
    task automatic cyc(input logic [3:0] r, input logic [23:0] e);
        @(negedge clk);
        bus.req     = r;
        bus.data_in = {d[3], d[2], d[1], d[0]};
        exp_q.push_back(e);
    endtask

    // Monitor: compare every cycle for which an expectation is pending.
    initial begin
        logic [23:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_n++;
                chk($sformatf("cycle%0d", cyc_n), actual(), e);
            end
        end
    end

    initial begin
        d[0] = 16'h1111;
        d[1] = 16'h2222;
        d[2] = 16'hBEEF;
        d[3] = 16'h3333;
        bus.req     = '0;
        bus.data_in = {d[3], d[2], d[1], d[0]};
`ifdef SEG_ARB_BLINK_EN
        bus.blink   = '0;
`endif

        repeat (2) @(negedge clk);
        chk("reset_state", actual(), mk(4'b0000, 2'd0, 16'h0000));
        rst_n = 1'b1;

        // First grant and release with a waiting requester.
        cyc(4'b0000, mk(4'b0000, 2'd0, 16'h0000));
        cyc(4'b0100, mk(4'b0100, 2'd2, 16'hBEEF));
        cyc(4'b0100, mk(4'b0100, 2'd2, 16'hBEEF));
        cyc(4'b0101, mk(4'b0100, 2'd2, 16'hBEEF));
        cyc(4'b0001, mk(4'b0000, 2'd2, 16'hBEEF));
        cyc(4'b0001, mk(4'b0001, 2'd0, 16'h1111));

        // Two contenders alternate after exactly 8 owned cycles each.
        for (int i = 0; i < 7; i++) cyc(4'b0011, mk(4'b0001, 2'd0, 16'h1111));
        cyc(4'b0011, mk(4'b0000, 2'd0, 16'h1111));
        for (int i = 0; i < 8; i++) cyc(4'b0011, mk(4'b0010, 2'd1, 16'h2222));
        cyc(4'b0011, mk(4'b0000, 2'd1, 16'h2222));
        cyc(4'b0011, mk(4'b0001, 2'd0, 16'h1111));

        // Sole requester keeps the display; owner data tracked, non-owner ignored.
        cyc(4'b1000, mk(4'b0000, 2'd0, 16'h1111));
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                d[3] = 16'hA5A5;
                d[0] = 16'hFFFF;
            end
            cyc(4'b1000, mk(4'b1000, 2'd3, (i >= 50) ? 16'hA5A5 : 16'h3333));
        end

        // Asynchronous reset between edges while owner 3 holds the display.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.req = '0;
        #1;
        chk("async_reset", actual(), mk(4'b0000, 2'd0, 16'h0000));
        @(negedge clk);
        rst_n = 1'b1;
        d[0] = 16'h1111;
        d[3] = 16'h3333;
        cyc(4'b1111, mk(4'b0001, 2'd0, 16'h1111));

        // Request rising during BLANK, then a single-cycle pulse from IDLE.
        cyc(4'b0001, mk(4'b0001, 2'd0, 16'h1111));
        cyc(4'b0000, mk(4'b0000, 2'd0, 16'h1111));
        cyc(4'b0100, mk(4'b0100, 2'd2, 16'hBEEF));
        cyc(4'b0000, mk(4'b0000, 2'd2, 16'hBEEF));
        cyc(4'b0000, mk(4'b0000, 2'd2, 16'hBEEF));
        cyc(4'b0010, mk(4'b0010, 2'd1, 16'h2222));
        cyc(4'b0000, mk(4'b0000, 2'd1, 16'h2222));
        cyc(4'b0000, mk(4'b0000, 2'd1, 16'h2222));

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display driver among N_REQ requesters, for example a CPU debug value, the PC and a bus monitor.
- Uses req/gnt handshake, round-robin selection and a minimum-ownership hold time.
- Drives the driver's 16-bit data and enable inputs.
- Inserts a one-cycle blank on every owner change so digits from two sources never mix.

Parameters:
- N_REQ, 4: number of requesters; legal range 1..8.
- HOLD_CYCLES, 25000000: minimum cycles the owner keeps the display before another pending requester may preempt it; must be ≥1.
- BLINK_CYCLES, 12500000: half-period of blink. Exists only with SEG_ARB_BLINK_EN.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req, input, N_REQ: request per source; level-held while the source wants the display.
- data_in, input, 16*N_REQ: 4-nibble value per source; source i occupies [16i+15:16i].
- gnt, output, N_REQ: one-hot grant, or all zero.
- owner, output, $clog2(N_REQ) (minimum 1): index of the current owner.
- owner_valid, output, 1: gnt is non-zero.
- disp_data, output, 16: value to the display driver.
- disp_enable, output, 1: display enable to the driver.

Behaviour:
- Reset, asynchronous and effective immediately, including mid-operation:
  - state=IDLE, gnt=0, owner=0, owner_valid=0.
  - disp_data=16'h0000, disp_enable=0.
  - hold counter=0; round-robin last-owner pointer=N_REQ-1, so the first search starts at 0.
- States:
  - IDLE: no owner, disp_enable=0, disp_data holds its last value.
  - GRANT: one owner; gnt[owner]=1, owner_valid=1, disp_enable=1.
  - BLANK: a single cycle; gnt=0, owner_valid=0, disp_enable=0, disp_data held.
- Round-robin pick: first asserted req at index last+1, last+2, … mod N_REQ.
- IDLE→GRANT: if req≠0 at edge t, then from t+1 gnt/owner reflect the pick and disp_enable=1. disp_data loads data_in[pick] at that same edge. Grant latency is 1 cycle.
- In GRANT:
  - disp_data <= data_in[owner] every cycle (1-cycle data latency).
  - hold counter increments and saturates at HOLD_CYCLES-1.
- GRANT→BLANK occurs when either:
  - req[owner]=0 (release, takes effect regardless of the counter), or
  - the counter equals HOLD_CYCLES-1 and some other req bit is set (preemption; the preempted source keeps req and is re-served in round-robin order).
- On entering BLANK: last-owner pointer <= owner; counter <= 0.
- BLANK→GRANT: if req≠0, the pick uses the updated pointer. BLANK→IDLE: if req=0.
- A sole requester holding req keeps the display indefinitely and the counter stays saturated. With N_REQ=1, preemption never occurs.
- A single-cycle req pulse in IDLE is still granted for one cycle, then released through BLANK.
- If release and preemption are true in the same cycle, treat it as a release; the result is identical.
- A req rising on a non-owner during BLANK is considered in that cycle's pick.
- data_in changes of non-owners are ignored.

Optional Feature:
- Macro: SEG_ARB_BLINK_EN.
- Enabled:
  - Adds input blink, N_REQ bits, and parameter BLINK_CYCLES.
  - In GRANT with blink[owner]=1, disp_enable toggles every BLINK_CYCLES cycles, starting high.
  - The blink counter resets on entry to GRANT and whenever blink[owner]=0.
  - gnt and disp_data are unaffected.
- Disabled: the blink port and parameter are absent; disp_enable is exactly "state==GRANT".

Decomposition:
- Package seg_arb_pkg:
  - typedef enum logic [1:0] {IDLE, GRANT, BLANK} seg_arb_state_t.
  - localparam DISP_W=16.
- Sub-module rr_picker: combinational; inputs req and last pointer, outputs found and index. It is reused by both the IDLE and BLANK transitions.

Test Plan:
- Reset then req=4'b0100, data_in[2]=16'hBEEF → one cycle later gnt=4'b0100, owner=2, disp_enable=1, disp_data=16'hBEEF.
- Owner 2 drops req at cycle t with req[0] high → t+1 BLANK (gnt=0, disp_enable=0); t+2 gnt=4'b0001, disp_data=data_in[0].
- HOLD_CYCLES=8, req=4'b0011 held → owner 0 for 8 cycles, BLANK, then owner 1 for 8, then owner 0; each owner gets exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=8, only req[3] held for 100 cycles → gnt stays 4'b1000 throughout; no BLANK cycles.
- rst_n low asynchronously mid-GRANT (between edges) → gnt, disp_enable and owner_valid go to 0 immediately. After release, the first pick with req=4'b1111 is owner 0.
- SEG_ARB_BLINK_EN, BLINK_CYCLES=4, blink[1]=1 while owner 1 → disp_enable pattern 1111 0000 1111 …; clearing blink[1] forces disp_enable=1 the next cycle.
